// File: rtl/hbconsole_mux_pkg.sv
// hbmux_pkg: shared marker byte, FSM state types and helper for the hexbus/console mux
package hbmux_pkg;
  localparam logic [7:0] HB_MARK = 8'hFF;
  typedef enum logic {TX_IDLE, TX_CHAN} tx_state_t;
  typedef enum logic {RX_NORM, RX_SEL} rx_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hbconsole_mux_if.sv
// hbconsole_mux_if: hexbus, console and UART byte streams of the mux; slave is the mux side
interface hbconsole_mux_if #(parameter int NCHAN = 2);
  logic                 i_hb_stb;
  logic [6:0]           i_hb_byte;
  logic                 o_hb_busy;
  logic [NCHAN-1:0]     i_console_stb;
  logic [7*NCHAN-1:0]   i_console_data;
  logic [NCHAN-1:0]     o_console_busy;
  logic                 o_tx_stb;
  logic [7:0]           o_tx_data;
  logic                 i_tx_busy;
  logic                 i_rx_stb;
  logic [7:0]           i_rx_byte;
  logic                 o_hb_rx_stb;
  logic [7:0]           o_hb_rx_byte;
  logic [NCHAN-1:0]     o_console_stb;
  logic [6:0]           o_console_data;
  modport slave (
    input  i_hb_stb, i_hb_byte, i_console_stb, i_console_data, i_tx_busy, i_rx_stb, i_rx_byte,
    output o_hb_busy, o_console_busy, o_tx_stb, o_tx_data, o_hb_rx_stb, o_hb_rx_byte,
           o_console_stb, o_console_data
  );
  modport master (
    output i_hb_stb, i_hb_byte, i_console_stb, i_console_data, i_tx_busy, i_rx_stb, i_rx_byte,
    input  o_hb_busy, o_console_busy, o_tx_stb, o_tx_data, o_hb_rx_stb, o_hb_rx_byte,
           o_console_stb, o_console_data
  );
endinterface

// File: rtl/hbconsole_mux_hbcfifo.sv
// hbcfifo: 7-bit synchronous first-word-fall-through FIFO, 2**LGFIFO deep, writes dropped when full
module hbcfifo #(parameter int LGFIFO = 4) (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic       i_wr,
  input  logic [6:0] i_data,
  input  logic       i_rd,
  output logic [6:0] o_data,
  output logic       o_full,
  output logic       o_empty
);
  localparam logic [LGFIFO:0] ONE = 1;
  logic [LGFIFO:0] r_wptr, r_rptr;
  logic [6:0]      r_mem [2**LGFIFO];
  logic            w_wr, w_rd;
  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[LGFIFO] != r_rptr[LGFIFO]) && (r_wptr[LGFIFO-1:0] == r_rptr[LGFIFO-1:0]);
  assign o_data  = r_mem[r_rptr[LGFIFO-1:0]];
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_wptr[LGFIFO-1:0]] <= i_data;
  always_ff @(posedge i_clk or negedge i_areset_n)
    if (!i_areset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + ONE;
      if (w_rd) r_rptr <= r_rptr + ONE;
    end
endmodule

// File: rtl/hbconsole_mux.sv
// hbconsole_mux: merges hexbus and NCHAN console channels onto one UART byte stream and splits rx back.
// Define HBCONSOLE_RR_EN for round-robin console selection instead of lowest-index priority.
module hbconsole_mux import hbmux_pkg::*; #(
  parameter int NCHAN  = 2,
  parameter int LGFIFO = 4
) (
  input logic           i_clk,
  input logic           i_areset_n,
  hbconsole_mux_if.slave bus
);
  localparam logic [7:0] NCH8 = 8'(NCHAN);
  logic [NCHAN-1:0] w_empty, w_full, w_pop;
  logic [6:0]       w_fdata [NCHAN];
  logic [6:0]       w_sel, w_sel_data;
  logic             w_any;
  tx_state_t        r_tx_state, w_tx_nxt;
  rx_state_t        r_rx_state, w_rx_nxt;
  logic             r_tx_stb, w_slot_free, w_load, w_pop_en, w_mark;
  logic [7:0]       r_tx_data, w_load_data;
  logic [6:0]       r_pend, w_pend_nxt, r_tx_ch, w_txch_nxt, r_rx_ch, w_rxch_nxt;
  logic             w_rx_norm, r_hb_rx_stb;
  logic [7:0]       r_hb_rx_byte;
  logic [NCHAN-1:0] w_con_stb, r_con_stb;
  logic [6:0]       r_con_data;
  for (genvar k = 0; k < NCHAN; k++) begin : g_fifo
    hbcfifo #(.LGFIFO(LGFIFO)) u_fifo (
      .i_clk      (i_clk),
      .i_areset_n (i_areset_n),
      .i_wr       (bus.i_console_stb[k]),
      .i_data     (bus.i_console_data[7*k +: 7]),
      .i_rd       (w_pop[k]),
      .o_data     (w_fdata[k]),
      .o_full     (w_full[k]),
      .o_empty    (w_empty[k])
    );
  end
`ifdef HBCONSOLE_RR_EN
  logic [6:0] r_last, w_hi, w_lo;
  logic       w_any_hi;
  // channels above the last served one win; otherwise wrap to the lowest non-empty
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_any_hi = 1'b0;
    w_any    = 1'b0;
    for (int j = NCHAN - 1; j >= 0; j--) begin
      if (!w_empty[j]) begin
        w_lo  = 7'(j);
        w_any = 1'b1;
      end
      if (!w_empty[j] && 7'(j) > r_last) begin
        w_hi     = 7'(j);
        w_any_hi = 1'b1;
      end
    end
    w_sel = w_any_hi ? w_hi : w_lo;
  end
  // a marker aims the next search at the channel just announced
  always_ff @(posedge i_clk or negedge i_areset_n)
    if (!i_areset_n) r_last <= '0;
    else if (w_pop_en) r_last <= w_sel;
    else if (w_mark) r_last <= (w_sel == '0) ? 7'(NCHAN - 1) : w_sel - 7'd1;
`else
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int j = NCHAN - 1; j >= 0; j--)
      if (!w_empty[j]) begin
        w_sel = 7'(j);
        w_any = 1'b1;
      end
  end
`endif
  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < NCHAN; j++) begin
      if (7'(j) == w_sel) w_sel_data = w_fdata[j];
      w_pop[j] = w_pop_en && (7'(j) == w_sel);
    end
  end
  assign w_slot_free = !r_tx_stb || !bus.i_tx_busy;
  always_comb begin
    w_tx_nxt    = r_tx_state;
    w_load      = 1'b0;
    w_load_data = r_tx_data;
    w_pop_en    = 1'b0;
    w_mark      = 1'b0;
    w_pend_nxt  = r_pend;
    w_txch_nxt  = r_tx_ch;
    if (w_slot_free) begin
      if (r_tx_state == TX_CHAN) begin
        w_load      = 1'b1;
        w_load_data = {1'b1, r_pend};
        w_txch_nxt  = r_pend;
        w_tx_nxt    = TX_IDLE;
      end else if (bus.i_hb_stb) begin
        w_load      = 1'b1;
        w_load_data = {1'b1, bus.i_hb_byte};
      end else if (w_any && w_sel == r_tx_ch) begin
        w_load      = 1'b1;
        w_load_data = {1'b0, w_sel_data};
        w_pop_en    = 1'b1;
      end else if (w_any) begin
        w_load      = 1'b1;
        w_load_data = HB_MARK;
        w_mark      = 1'b1;
        w_pend_nxt  = w_sel;
        w_tx_nxt    = TX_CHAN;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_areset_n)
    if (!i_areset_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_stb   <= 1'b0;
      r_tx_data  <= '0;
      r_pend     <= '0;
      r_tx_ch    <= '0;
    end else begin
      r_tx_state <= w_tx_nxt;
      r_pend     <= w_pend_nxt;
      r_tx_ch    <= w_txch_nxt;
      if (w_slot_free) begin
        r_tx_stb  <= w_load;
        r_tx_data <= w_load_data;
      end
    end
  always_comb begin
    w_rx_nxt   = r_rx_state;
    w_rxch_nxt = r_rx_ch;
    w_rx_norm  = bus.i_rx_stb && r_rx_state == RX_NORM && bus.i_rx_byte != HB_MARK;
    if (bus.i_rx_stb) begin
      w_rx_nxt = (r_rx_state == RX_NORM && bus.i_rx_byte == HB_MARK) ? RX_SEL : RX_NORM;
      if (r_rx_state == RX_SEL && bus.i_rx_byte[7] && {1'b0, bus.i_rx_byte[6:0]} < NCH8)
        w_rxch_nxt = bus.i_rx_byte[6:0];
    end
    for (int j = 0; j < NCHAN; j++)
      w_con_stb[j] = w_rx_norm && !bus.i_rx_byte[7] && 7'(j) == r_rx_ch;
  end
  always_ff @(posedge i_clk or negedge i_areset_n)
    if (!i_areset_n) begin
      r_rx_state   <= RX_NORM;
      r_rx_ch      <= '0;
      r_hb_rx_stb  <= 1'b0;
      r_hb_rx_byte <= '0;
      r_con_stb    <= '0;
      r_con_data   <= '0;
    end else begin
      r_rx_state  <= w_rx_nxt;
      r_rx_ch     <= w_rxch_nxt;
      r_hb_rx_stb <= w_rx_norm && bus.i_rx_byte[7];
      r_con_stb   <= w_con_stb;
      if (w_rx_norm && bus.i_rx_byte[7]) r_hb_rx_byte <= bus.i_rx_byte;
      if (w_rx_norm && !bus.i_rx_byte[7]) r_con_data <= bus.i_rx_byte[6:0];
    end
  assign bus.o_hb_busy      = !w_slot_free || r_tx_state == TX_CHAN;
  assign bus.o_console_busy = w_full;
  assign bus.o_tx_stb       = r_tx_stb;
  assign bus.o_tx_data      = r_tx_data;
  assign bus.o_hb_rx_stb    = r_hb_rx_stb;
  assign bus.o_hb_rx_byte   = r_hb_rx_byte;
  assign bus.o_console_stb  = r_con_stb;
  assign bus.o_console_data = r_con_data;
endmodule
